// File: rtl/aes_key_expand128.sv
// AES-128 key schedule: expands a cipher key into round keys 0..10, one per round,
// using an external word S-box reached through a start/ready handshake.
module aes_key_expand128 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] key_i,
    output logic         sbox_start_o,
    output logic [31:0]  sbox_word_o,
    output logic         sbox_decrypt_o,
    input  logic [31:0]  sbox_data_i,
    input  logic         sbox_ready_i,
    output logic         rkey_valid_o,
    output logic [3:0]   rkey_idx_o,
    output logic [127:0] rkey_o,
    output logic         busy_o,
    output logic         ready_o,
    output logic         error_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_UPD,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      w0;
    logic [31:0]      w1;
    logic [31:0]      w2;
    logic [31:0]      w3;
    logic [3:0]       rnd;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
    logic [31:0]      tmp;
    logic [31:0]      nw0;
    logic [31:0]      nw1;
    logic [31:0]      nw2;
    logic [31:0]      nw3;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Next-round words are formed straight from the S-box response so they can be
    // latched on the same edge that sbox_ready_i is accepted.
    always_comb begin
        tmp = sbox_data_i ^ {rcon(rnd), 24'h000000};
        nw0 = w0 ^ tmp;
        nw1 = w1 ^ nw0;
        nw2 = w2 ^ nw1;
        nw3 = w3 ^ nw2;
    end

    assign timeout_hit    = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign sbox_decrypt_o = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        sbox_start_o = 1'b0;
        rkey_valid_o = 1'b0;
        ready_o      = 1'b0;
        busy_o       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                rkey_valid_o = 1'b1;
                state_next   = S_REQ;
            end
            S_REQ: begin
                sbox_start_o = 1'b1;
                state_next   = S_WAIT;
            end
            S_WAIT: begin
                if (sbox_ready_i) begin
                    state_next = S_UPD;
                end else if (timeout_hit) begin
                    state_next = S_IDLE;
                end
            end
            S_UPD: begin
                rkey_valid_o = 1'b1;
                state_next   = (rnd == 4'd10) ? S_DONE : S_REQ;
            end
            S_DONE: begin
                ready_o    = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Key words, round counter, wait timer and the held output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            w0          <= '0;
            w1          <= '0;
            w2          <= '0;
            w3          <= '0;
            rnd         <= '0;
            wait_cnt    <= '0;
            rkey_o      <= '0;
            rkey_idx_o  <= '0;
            sbox_word_o <= '0;
            error_o     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        {w0, w1, w2, w3} <= key_i;
                        rkey_o           <= key_i;
                        rkey_idx_o       <= 4'd0;
                        error_o          <= 1'b0;
                        rnd              <= 4'd1;
                    end
                end
                S_LOAD: begin
                    sbox_word_o <= rot_word(w3);
                end
                S_REQ: begin
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (sbox_ready_i) begin
                        w0         <= nw0;
                        w1         <= nw1;
                        w2         <= nw2;
                        w3         <= nw3;
                        rkey_o     <= {nw0, nw1, nw2, nw3};
                        rkey_idx_o <= rnd;
                    end else if (timeout_hit) begin
                        error_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_UPD: begin
                    // w3 already holds this round's last word, so the next request uses it directly.
                    if (rnd != 4'd10) begin
                        rnd         <= rnd + 4'd1;
                        sbox_word_o <= rot_word(w3);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand128.sv
// Directed bench for aes_key_expand128 with a behavioural word S-box responder.
module tb_aes_key_expand128;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         start_to;
    logic [127:0] key;

    logic         sbox_start;
    logic [31:0]  sbox_word;
    logic         sbox_decrypt;
    logic [31:0]  sbox_data;
    logic         sbox_ready;
    logic         rkey_valid;
    logic [3:0]   rkey_idx;
    logic [127:0] rkey;
    logic         busy;
    logic         ready;
    logic         error;

    logic         sbox_start_t;
    logic [31:0]  sbox_word_t;
    logic         sbox_decrypt_t;
    logic [31:0]  sbox_data_t;
    logic         sbox_ready_t;
    logic         rkey_valid_t;
    logic [3:0]   rkey_idx_t;
    logic [127:0] rkey_t;
    logic         busy_t;
    logic         ready_t;
    logic         error_t;

    int           n_cmp = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           n_valid = 0;
    int           n_req = 0;
    int           n_ready = 0;
    int           n_ready_t = 0;
    logic [3:0]   got_idx [16];
    logic [127:0] got_key [16];
    int           valid_cyc [16];
    logic [31:0]  first_word;
    int           fixed_lat = 3;
    bit           rand_lat = 1'b0;
    logic [127:0] fips_rk [11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 clk = ~clk;

    aes_key_expand128 dut (
        .clk(clk), .rst(rst), .start_i(start), .key_i(key),
        .sbox_start_o(sbox_start), .sbox_word_o(sbox_word), .sbox_decrypt_o(sbox_decrypt),
        .sbox_data_i(sbox_data), .sbox_ready_i(sbox_ready),
        .rkey_valid_o(rkey_valid), .rkey_idx_o(rkey_idx), .rkey_o(rkey),
        .busy_o(busy), .ready_o(ready), .error_o(error)
    );

    aes_key_expand128 #(.TIMEOUT(8)) dut_to (
        .clk(clk), .rst(rst), .start_i(start_to), .key_i(key),
        .sbox_start_o(sbox_start_t), .sbox_word_o(sbox_word_t), .sbox_decrypt_o(sbox_decrypt_t),
        .sbox_data_i(sbox_data_t), .sbox_ready_i(sbox_ready_t),
        .rkey_valid_o(rkey_valid_t), .rkey_idx_o(rkey_idx_t), .rkey_o(rkey_t),
        .busy_o(busy_t), .ready_o(ready_t), .error_o(error_t)
    );

    assign sbox_data_t  = 32'h0;
    assign sbox_ready_t = 1'b0;

    // Reference S-box: GF(2^8) inverse followed by the AES affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, b);
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]), sbox_byte(w[15:8]), sbox_byte(w[7:0])};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Word S-box responder: answers each request after a fixed or random latency.
    initial begin
        sbox_ready = 1'b0;
        sbox_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (sbox_start) begin
                automatic logic [31:0] w = sbox_word;
                automatic int lat = rand_lat ? int'($urandom_range(20, 1)) : fixed_lat;
                repeat (lat) @(negedge clk);
                sbox_data  = sub_word(w);
                sbox_ready = 1'b1;
                @(negedge clk);
                sbox_ready = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rkey_valid) begin
            if (n_valid < 16) begin
                got_idx[n_valid]   = rkey_idx;
                got_key[n_valid]   = rkey;
                valid_cyc[n_valid] = cyc;
            end
            n_valid++;
        end
        if (sbox_start) begin
            if (n_req == 0) first_word = sbox_word;
            n_req++;
        end
        if (ready) n_ready++;
        if (ready_t) n_ready_t++;
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearMon();
        n_valid = 0;
        n_req   = 0;
        n_ready = 0;
        for (int i = 0; i < 16; i++) begin
            got_idx[i] = '0;
            got_key[i] = '0;
            valid_cyc[i] = 0;
        end
    endtask

    task automatic applyStimulus(input logic [127:0] k);
        @(negedge clk);
        key   = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitReady(input string tag, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ready) break;
        end
        if (i == bound) checkOutput(tag, 0, 1);
    endtask

    task automatic waitIdx(input string tag, input logic [3:0] idx, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (rkey_valid && rkey_idx == idx) break;
        end
        if (i == bound) checkOutput(tag, 0, 1);
    endtask

    task automatic waitReq(input string tag, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            if (sbox_start) break;
        end
        if (i == bound) checkOutput(tag, 0, 1);
    endtask

    task automatic checkFips(input string tag);
        checkOutput({tag, "_nvalid"}, n_valid, 11);
        for (int i = 0; i < 11; i++) begin
            checkOutput($sformatf("%s_idx%0d", tag, i), got_idx[i], i);
            checkOutput($sformatf("%s_key%0d", tag, i), got_key[i], fips_rk[i]);
        end
        checkOutput({tag, "_nreq"}, n_req, 10);
        checkOutput({tag, "_nready"}, n_ready, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b1;
        start = 1'b0;
        start_to = 1'b0;
        key = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ctl", {busy, ready, rkey_valid, sbox_start, error, sbox_decrypt}, 0);
        checkOutput("reset_rkey", rkey, 0);
        checkOutput("reset_word", sbox_word, 0);
        checkOutput("reset_idx", rkey_idx, 0);
        rst = 1'b0;

        $display("[TB] FIPS key, fixed S-box latency 3");
        clearMon();
        applyStimulus(FIPS_KEY);
        waitReady("t1_ready_timeout", 500);
        @(negedge clk);
        checkFips("t1");
        checkOutput("t1_latency", valid_cyc[10] - valid_cyc[0], 50);
        checkOutput("t1_word1", first_word, 32'hcf4f3c09);
        checkOutput("t1_idle_busy", busy, 0);
        checkOutput("t1_hold_rkey", rkey, fips_rk[10]);

        $display("[TB] FIPS key, random S-box latency");
        rand_lat = 1'b1;
        clearMon();
        applyStimulus(FIPS_KEY);
        waitReady("t2_ready_timeout", 1000);
        @(negedge clk);
        checkFips("t2");
        rand_lat = 1'b0;

        $display("[TB] start while busy, then restart right after DONE");
        clearMon();
        applyStimulus(FIPS_KEY);
        waitIdx("t3_idx4_timeout", 4'd4, 300);
        key   = 128'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitReady("t3_ready_timeout", 500);
        @(negedge clk);
        key   = 128'h0;
        start = 1'b1;
        checkFips("t3");
        clearMon();
        @(negedge clk);
        start = 1'b0;
        checkOutput("t3_restart_busy", busy, 1);
        checkOutput("t3_restart_rkey", rkey, 128'h0);

        waitReady("t4_ready_timeout", 500);
        key   = FIPS_KEY;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("t4_zero_rk1", got_key[1], 128'h62636363626363636263636362636363);
        checkOutput("t4_zero_word1", first_word, 32'h00000000);
        checkOutput("t4_nvalid", n_valid, 11);
        @(negedge clk);
        checkOutput("t4_done_start_ignored", busy, 0);

        $display("[TB] S-box timeout with TIMEOUT=8");
        @(negedge clk);
        key = FIPS_KEY;
        start_to = 1'b1;
        @(negedge clk);
        start_to = 1'b0;
        begin
            int i;
            for (i = 0; i < 10; i++) begin
                @(negedge clk);
                if (sbox_start_t) break;
            end
            if (i == 10) checkOutput("t5_req_timeout", 0, 1);
        end
        checkOutput("t5_word", sbox_word_t, 32'hcf4f3c09);
        repeat (4) @(negedge clk);
        checkOutput("t5_mid_wait", {busy_t, error_t}, 2'b10);
        repeat (5) @(negedge clk);
        checkOutput("t5_timed_out", {busy_t, error_t}, 2'b01);
        checkOutput("t5_no_ready", n_ready_t, 0);
        @(negedge clk);
        start_to = 1'b1;
        @(negedge clk);
        start_to = 1'b0;
        checkOutput("t5_restart_clears", {busy_t, error_t}, 2'b10);

        $display("[TB] reset during WAIT at round 6");
        clearMon();
        applyStimulus(FIPS_KEY);
        waitIdx("t6_idx6_timeout", 4'd6, 300);
        waitReq("t6_req_timeout", 20);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6_reset_ctl", {busy, ready, rkey_valid, sbox_start, error}, 0);
        checkOutput("t6_reset_rkey", rkey, 0);
        checkOutput("t6_reset_word", sbox_word, 0);
        checkOutput("t6_reset_idx", rkey_idx, 0);
        repeat (10) @(negedge clk);
        checkOutput("t6_late_ready_ignored", {busy, rkey}, 0);
        checkOutput("t6_pulse_count", n_valid, 7);
        checkOutput("t6_no_ready", n_ready, 0);
        clearMon();
        applyStimulus(FIPS_KEY);
        waitReady("t6_ready_timeout", 500);
        @(negedge clk);
        checkFips("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
